// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state, id-width helper and slave-id field position for bus_arbiter
package bus_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, XFER, RELEASE} arb_state_e;
    // slave id occupies the top ID_W bits of the bus, offset down from the MSB by this many bits
    localparam int SLV_ID_OFS = 0;
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: shared bus bundle; master = device side, slave = arbiter side
interface bus_arbiter_if import bus_pkg::*; #(
    parameter int NUM_DEVICES = 8,
    parameter int D_WIDTH = 32,
    parameter int C_WIDTH = 8
);
    localparam int ID_W = id_w(NUM_DEVICES);
    logic [NUM_DEVICES-1:0] req;
    logic [NUM_DEVICES*D_WIDTH-1:0] bus_in;
    logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in;
    logic [NUM_DEVICES-1:0] master_ack;
    logic [NUM_DEVICES-1:0] slave_en;
    logic [D_WIDTH-1:0] bus_out;
    logic [C_WIDTH-1:0] ctrl_out;
    logic [ID_W-1:0] grant_id;
    logic decode_err;
    logic timeout_err;
    modport master (
        output req, bus_in, ctrl_in,
        input master_ack, slave_en, bus_out, ctrl_out, grant_id, decode_err, timeout_err
    );
    modport slave (
        input req, bus_in, ctrl_in,
        output master_ack, slave_en, bus_out, ctrl_out, grant_id, decode_err, timeout_err
    );
endinterface

// File: rtl/bus_arbiter_picker.sv
// rr_priority_picker: round-robin winner search starting at last_grant+1, wrapping modulo NUM_DEVICES
module rr_priority_picker #(
    parameter int NUM_DEVICES = 8,
    parameter int ID_W = 3
) (
    input  logic [NUM_DEVICES-1:0] req,
    input  logic [ID_W-1:0]        last_grant,
    output logic [ID_W-1:0]        winner,
    output logic                   valid
);
    logic [ID_W-1:0] idx;
    // walk farthest-first so the nearest requester after last_grant overwrites last
    always_comb begin
        winner = '0;
        idx = '0;
        valid = |req;
        for (int i = NUM_DEVICES; i >= 1; i--) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_DEVICES);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin shared-bus arbiter with slave decode; optional grant timeout via BUS_ARB_TIMEOUT_EN
module bus_arbiter import bus_pkg::*; #(
    parameter int NUM_DEVICES = 8,
    parameter int D_WIDTH = 32,
    parameter int C_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic clk,
    input logic reset_L,
    bus_arbiter_if.slave bus
);
    localparam int ID_W = id_w(NUM_DEVICES);
    arb_state_e st, st_n;
    logic [NUM_DEVICES-1:0] ack, ack_n, sen, sen_n;
    logic [ID_W-1:0] gid, gid_n, last, last_n, winner, slv_id;
    logic valid, derr, derr_n, owner_req;
    logic [D_WIDTH-1:0] bus_or;
    logic [C_WIDTH-1:0] ctrl_or;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer, timer_n;
    logic terr, terr_n;
`endif

    rr_priority_picker #(.NUM_DEVICES(NUM_DEVICES), .ID_W(ID_W)) picker (
        .req(bus.req), .last_grant(last), .winner(winner), .valid(valid)
    );

    always_comb begin
        bus_or = '0;
        ctrl_or = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            bus_or = bus_or | bus.bus_in[i*D_WIDTH +: D_WIDTH];
            ctrl_or = ctrl_or | bus.ctrl_in[i*C_WIDTH +: C_WIDTH];
        end
    end

    assign slv_id = bus_or[D_WIDTH-1-SLV_ID_OFS -: ID_W];
    assign owner_req = bus.req[gid];

    always_comb begin
        st_n = st;
        ack_n = ack;
        sen_n = sen;
        gid_n = gid;
        last_n = last;
        derr_n = 1'b0;
        case (st)
            IDLE: if (valid) begin
                ack_n = NUM_DEVICES'(1) << winner;
                gid_n = winner;
                last_n = winner;
                st_n = ADDR;
            end
            ADDR: if (!owner_req) begin
                ack_n = '0;
                st_n = RELEASE;
            end else begin
                sen_n = (int'(slv_id) < NUM_DEVICES) ? NUM_DEVICES'(1) << slv_id : '0;
                derr_n = int'(slv_id) >= NUM_DEVICES;
                st_n = XFER;
            end
            XFER: if (!owner_req) begin
                ack_n = '0;
                sen_n = '0;
                st_n = RELEASE;
            end
            default: st_n = IDLE;
        endcase
`ifdef BUS_ARB_TIMEOUT_EN
        timer_n = (st == ADDR || st == XFER) ? timer + TW'(1) : '0;
        terr_n = 1'b0;
        // revocation wins over any decode or release decision made this cycle
        if ((st == ADDR || st == XFER) && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            ack_n = '0;
            sen_n = '0;
            derr_n = 1'b0;
            terr_n = 1'b1;
            st_n = RELEASE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st <= IDLE;
            ack <= '0;
            sen <= '0;
            gid <= '0;
            last <= ID_W'(NUM_DEVICES - 1);
            derr <= 1'b0;
        end else begin
            st <= st_n;
            ack <= ack_n;
            sen <= sen_n;
            gid <= gid_n;
            last <= last_n;
            derr <= derr_n;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            timer <= '0;
            terr <= 1'b0;
        end else begin
            timer <= timer_n;
            terr <= terr_n;
        end
    end
    assign bus.timeout_err = terr;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.master_ack = ack;
    assign bus.slave_en = sen;
    assign bus.grant_id = gid;
    assign bus.decode_err = derr;
    assign bus.bus_out = bus_or;
    assign bus.ctrl_out = ctrl_or;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_DEVICES, default 8, number of bus ports (2..16).
REQ-002 SHALL have parameter D_WIDTH, default 32, bus data width.
REQ-003 SHALL have parameter C_WIDTH, default 8, bus control width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum grant length in cycles (≥4).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset_L  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_DEVICES  per-port master bus request.
REQ-008 bus_in  input  NUM_DEVICES*D_WIDTH  flattened port data; port i at [i*D_WIDTH +: D_WIDTH].
REQ-009 ctrl_in  input  NUM_DEVICES*C_WIDTH  flattened port control, same packing.
REQ-010 master_ack  output  NUM_DEVICES  one-hot grant to the owning master.
REQ-011 slave_en  output  NUM_DEVICES  one-hot select of the addressed slave.
REQ-012 bus_out / ctrl_out  output  D_WIDTH / C_WIDTH  shared bus.
REQ-013 grant_id  output  ID_W  index of the current owner (ID_W = clog2(NUM_DEVICES)).
REQ-014 decode_err / timeout_err  output  1 each  single-cycle error pulses.

Function
REQ-015 bus_out and ctrl_out SHALL be the combinational bitwise OR of all ports; non-owning, non-selected ports drive zero.
REQ-016 FSM states SHALL be IDLE, ADDR, XFER, RELEASE.
REQ-017 IDLE: any req bit set -> register master_ack for the round-robin winner, go to ADDR; grant one cycle after req is seen.
REQ-018 Round-robin: search starts at last_grant+1 and wraps modulo NUM_DEVICES; last_grant updates on every grant.
REQ-019 ADDR: slave id = bus_out[D_WIDTH-1 -: ID_W]; id < NUM_DEVICES -> register one-hot slave_en, go to XFER.
REQ-020 ADDR, id ≥ NUM_DEVICES -> decode_err pulse, slave_en stays 0, go to XFER with no slave.
REQ-021 XFER: owner deasserting req -> go to RELEASE.
REQ-022 RELEASE: master_ack and slave_en SHALL be 0; next state IDLE; one dead cycle guaranteed between owners.
REQ-023 Requests from other ports during ADDR/XFER/RELEASE SHALL be held pending, never preempting.
REQ-024 Owner dropping req in ADDR SHALL go straight to RELEASE without asserting slave_en.
REQ-025 A port that is both owner and addressed slave SHALL receive both master_ack and slave_en.
REQ-026 master_ack and slave_en SHALL each be one-hot or zero in every cycle.

Reset
REQ-027 reset_L low SHALL force IDLE, master_ack=0, slave_en=0, grant_id=0, last_grant=NUM_DEVICES-1 (port 0 wins first), errors=0, timer=0.
REQ-028 Reset mid-transfer SHALL drop all grants immediately (asynchronous); req is sampled again from the first clock after release.

Configuration
REQ-029 Macro BUS_ARB_TIMEOUT_EN defined: a grant counter runs from ADDR entry; on reaching TIMEOUT_CYCLES in ADDR/XFER, pulse timeout_err and go to RELEASE regardless of req.
REQ-030 After a timeout the revoked port SHALL get lowest priority for the next grant (normal round-robin).
REQ-031 Macro undefined: no counter logic; timeout_err tied 0; grants last until req drops.

Structure
REQ-032 Shared package bus_pkg SHALL hold the FSM state typedef, the ID_W clog2 function and the slave-id field position constant.
REQ-033 Winner selection SHALL be a sub-module rr_priority_picker (inputs req, last_grant; outputs winner index and valid).

Verification
REQ-034 Reset, req=8'h80 -> master_ack=8'h80 one cycle later, grant_id=7.
REQ-035 req=8'h41 held, last_grant=6 at start -> grants alternate port 0, port 6, port 0, each separated by one RELEASE cycle with master_ack=0.
REQ-036 Port 7 granted, drives bus_in[7] top bits = 3'd3 in ADDR -> slave_en=8'h08 next cycle; bus_out equals bus_in[7] OR bus_in[3].
REQ-037 NUM_DEVICES=6, address id 7 -> decode_err single pulse, slave_en=0, bus released on req drop.
REQ-038 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, port 2 holds req -> timeout_err pulse 16 cycles after ADDR entry; pending port 5 granted after RELEASE.
REQ-039 reset_L low during XFER -> master_ack and slave_en 0 with no clock edge; the grant sequence restarts from port 0.
